spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave endpoint; the receive/respond end of the team's SPI master link (MSB first, single select line).
- Oversamples SCK, SSN and MOSI on the system clock.
- Shifts in one DATA_W-bit word per frame on MOSI and shifts out a host-loaded word on MISO.
- Exposes a one-entry TX holding buffer and an RX word/valid pulse to the local host logic.

Parameters:
- DATA_W, 8: bits per word; the master link is fixed at 8.
- SYNC_STAGES, 2: synchronizer flops on sck, ssn and mosi (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- spcon  in  8  control: bit6 = enable, bit2 = cpol, bit1 = cpha; other bits ignored.
- sck  in  1  SPI clock from the master.
- ssn  in  1  slave select, active-low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  MISO output enable; high only while selected and enabled.
- tx_data  in  DATA_W  word to transmit.
- tx_load  in  1  one-cycle pulse; writes tx_data into the TX buffer.
- tx_ready  out  1  TX buffer empty, can accept tx_load.
- rx_data  out  DATA_W  last fully received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  frame in progress.
- tx_underrun  out  1  sticky; a frame started with the TX buffer empty.
- underrun_clr  in  1  clears tx_underrun.

Behaviour:
- Reset values: miso 0, miso_oe 0, rx_data 0, rx_valid 0, tx_ready 1, busy 0, tx_underrun 0, TX buffer 0, bit count 0. Synchronizer flops reset to ssn=1, sck=0, mosi=0.
- Sync and edge detect: the synchronized ssn_s, sck_s and mosi_s are sampled against the previous cycle. A pin change acts internally SYNC_STAGES+1 clk later.
- Requirement: SCK high and low times are each at least SYNC_STAGES+2 clk periods.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on ssn_s falling while spcon[6]=1. On that transition:
  - latch cpol and cpha for the whole frame;
  - load the shift-out register from the TX buffer; set tx_ready=1;
  - if the buffer was empty, set tx_underrun and resend the last buffer contents;
  - busy=1, miso_oe=1; bit count = 0.
- Leading edge: sck_s moves away from the latched cpol. Trailing edge: sck_s returns to it.
- cpha=0:
  - miso = MSB of the shift-out register immediately on entering ACTIVE;
  - sample mosi_s on leading edges; shift out the next bit on trailing edges.
- cpha=1:
  - shift out the next bit on leading edges (the first leading edge presents the MSB);
  - sample on trailing edges.
- Each sample shifts mosi_s into the LSB of the shift-in register and increments the bit count.
- On sample DATA_W:
  - rx_data <= full word; rx_valid pulses for 1 clk;
  - bit count wraps to 0; the next TX word is reloaded (same underrun rule).
  - This allows back-to-back words while ssn stays low. For cpha=0, the new MSB appears on the trailing edge that follows the last sample.
- ACTIVE -> IDLE on ssn_s rising, or on spcon[6] falling:
  - a partial word is discarded, with no rx_valid;
  - miso_oe=0, busy=0, bit count cleared.
- Edges on sck while ssn_s is high are ignored.
- TX buffer:
  - tx_load with tx_ready=1 writes the buffer and sets tx_ready=0;
  - tx_load with tx_ready=0 overwrites the buffer, newest wins;
  - tx_load in the same cycle as a load into the shift register: tx_data bypasses straight into the shift register, tx_ready stays 1, no underrun.
- Sticky flag: underrun_clr clears tx_underrun. If a set and a clear happen in the same cycle, the set wins.
- Reset mid-frame: returns to IDLE immediately with the reset values above.

Decomposition:
- Shared package spi_pkg:
  - spcon bit-index constants SPCON_EN=6, SPCON_CPOL=2, SPCON_CPHA=1;
  - the state enumeration {IDLE, ACTIVE};
  - DATA_W default.
- One sub-module, spi_sync_edge: an N-stage synchronizer plus rise/fall detect. Instantiated three times.

Test Plan:
- Mode 0, tx_load 0xA5, master sends 0x3C -> miso shifts 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready=1 after the frame starts.
- Modes 1, 2 and 3, each with tx_load 0x81 and master sending 0x7E -> rx_data=0x7E in every mode; master receives 0x81.
- ssn held low for 2 words, tx_load 0x11 then 0x22 during the first word -> two rx_valid pulses; miso carries 0x11 then 0x22.
- Frame start with no tx_load after reset -> miso carries 0x00 and tx_underrun=1; underrun_clr brings it back to 0.
- ssn deasserted after 5 bits -> no rx_valid; busy=0 and miso_oe=0 within SYNC_STAGES+2 clk; next full frame of 0x55 is received correctly.
- spcon[6]=0 with ssn toggling -> busy, miso_oe and rx_valid all stay 0. Assert rst mid-frame -> all outputs return to reset values on the next clk.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: control-register bit positions, FSM states, word width.
package spi_pkg;

   localparam int DATA_W_DEF = 8;

   localparam int SPCON_EN   = 6;
   localparam int SPCON_CPOL = 2;
   localparam int SPCON_CPHA = 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detect; edges are visible STAGES clk after the pin moves.
// No backpressure; the output follows the input pin unconditionally.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sr;
   logic              q_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= {STAGES{RST_VAL}};
         q_d <= RST_VAL;
      end else begin
         sr  <= {sr[STAGES-2:0], din};
         q_d <= sr[STAGES-1];
      end
   end

   assign q    = sr[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint, MSB first; pin activity acts SYNC_STAGES+1 clk after it happens.
// Host side: one-entry TX buffer (tx_ready) and a one-cycle rx_valid pulse; no RX backpressure.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        spcon,
   input  logic              sck,
   input  logic              ssn,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              tx_underrun,
   input  logic              underrun_clr
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic              sck_rise, sck_fall, ssn_rise, ssn_fall, mosi_s;
   logic              unused_sck_s, unused_ssn_s, unused_mosi_rise, unused_mosi_fall, unused_spcon;
   logic [0:0]        state;
   logic              cpol_l, cpha_l;
   logic [DATA_W-1:0] shift_out, shift_in, tx_buf, next_word;
   logic [CNT_W-1:0]  bit_cnt;
   logic              lead_edge, trail_edge, start, stop, sample, shift, word_done, load_sr;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .din(sck), .q(unused_sck_s), .rise(sck_rise), .fall(sck_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
      .clk(clk), .rst(rst), .din(ssn), .q(unused_ssn_s), .rise(ssn_rise), .fall(ssn_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(mosi), .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   assign unused_spcon = ^{spcon[7], spcon[5:3], spcon[0]};

   always_comb begin
      lead_edge  = cpol_l ? sck_fall : sck_rise;
      trail_edge = cpol_l ? sck_rise : sck_fall;
      start      = (state == IDLE) && ssn_fall && spcon[SPCON_EN];
      stop       = (state == ACTIVE) && (ssn_rise || !spcon[SPCON_EN]);
      sample     = (state == ACTIVE) && !stop && (cpha_l ? trail_edge : lead_edge);
      shift      = (state == ACTIVE) && !stop && (cpha_l ? lead_edge : trail_edge);
      word_done  = sample && (bit_cnt == CNT_W'(DATA_W - 1));
      load_sr    = start || word_done;
      // A load pulse coinciding with a shift-register load goes straight through.
      next_word  = tx_load ? tx_data : tx_buf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cpol_l      <= 1'b0;
         cpha_l      <= 1'b0;
         shift_out   <= '0;
         shift_in    <= '0;
         tx_buf      <= '0;
         bit_cnt     <= '0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid <= 1'b0;

         if (load_sr) begin
            tx_ready <= 1'b1;
            if (tx_load) tx_buf <= tx_data;
         end else if (tx_load) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end

         if (load_sr && !tx_load && tx_ready) tx_underrun <= 1'b1;
         else if (underrun_clr)               tx_underrun <= 1'b0;

         if (start) begin
            state     <= ACTIVE;
            cpol_l    <= spcon[SPCON_CPOL];
            cpha_l    <= spcon[SPCON_CPHA];
            shift_out <= next_word;
            miso      <= next_word[DATA_W-1];
            busy      <= 1'b1;
            miso_oe   <= 1'b1;
            bit_cnt   <= '0;
         end else if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
         end else if (state == ACTIVE) begin
            if (sample) begin
               shift_in <= {shift_in[DATA_W-2:0], mosi_s};
               if (word_done) begin
                  rx_data   <= {shift_in[DATA_W-2:0], mosi_s};
                  rx_valid  <= 1'b1;
                  bit_cnt   <= '0;
                  shift_out <= next_word;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            if (shift) begin
               if (cpha_l) begin
                  miso      <= shift_out[DATA_W-1];
                  shift_out <= shift_out << 1;
               end else if (bit_cnt == '0) begin
                  // cpha=0 trailing edge right after a reload: present the new MSB unshifted.
                  miso <= shift_out[DATA_W-1];
               end else begin
                  miso      <= shift_out[DATA_W-2];
                  shift_out <= shift_out << 1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: behavioural SPI master, per-scenario tasks with inline checks.
module tb_spi_slave;

   localparam int H  = 6;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] spcon = 8'h40;
   logic       sck = 1'b0, ssn = 1'b1, mosi = 1'b0;
   logic       miso, miso_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy, tx_underrun;
   logic       underrun_clr = 1'b0;

   int checks = 0;
   int failures = 0;
   int rxv_cnt = 0, busy_cnt = 0, oe_cnt = 0;
   logic [7:0] rx_log[$];

   spi_slave #(.DATA_W(8), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .spcon(spcon), .sck(sck), .ssn(ssn), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .tx_underrun(tx_underrun), .underrun_clr(underrun_clr));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rx_log.push_back(rx_data);
      end
      if (busy) busy_cnt++;
      if (miso_oe) oe_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
   endtask

   task automatic set_mode(input logic [1:0] m);
      spcon = 8'h40 | {5'b0, m[1], m[0], 1'b0};
      sck   = m[1];
      wait_clk(H);
   endtask

   task automatic xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                       input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            mosi = tx[i];
            wait_clk(H);
            rx[i] = miso;
            sck   = ~cpol;
            wait_clk(H);
            sck = cpol;
         end else begin
            sck  = ~cpol;
            mosi = tx[i];
            wait_clk(H);
            rx[i] = miso;
            sck   = cpol;
            wait_clk(H);
         end
      end
   endtask

   task automatic frame(input logic [7:0] tx, input logic [1:0] m, output logic [7:0] rx);
      ssn = 1'b0;
      wait_clk(H);
      xfer(tx, m[1], m[0], 8, rx);
      wait_clk(H);
      ssn = 1'b1;
      wait_clk(H);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(1);
      checks++; if (miso !== 1'b0)        begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
      checks++; if (miso_oe !== 1'b0)     begin failures++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
      checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
      checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
      checks++; if (tx_ready !== 1'b1)    begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
   endtask

   task automatic test_underrun;
      logic [7:0] got;
      int base;
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      set_mode(2'd0);
      base = rxv_cnt;
      ssn = 1'b0;
      wait_clk(H);
      checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL ur_busy got=%b exp=1", busy); end
      checks++; if (miso_oe !== 1'b1)     begin failures++; $display("FAIL ur_miso_oe got=%b exp=1", miso_oe); end
      checks++; if (tx_underrun !== 1'b1) begin failures++; $display("FAIL ur_set got=%b exp=1", tx_underrun); end
      xfer(8'h96, 1'b0, 1'b0, 8, got);
      wait_clk(H);
      ssn = 1'b1;
      wait_clk(H);
      checks++; if (got !== 8'h00)          begin failures++; $display("FAIL ur_miso_word got=%h exp=00", got); end
      checks++; if (rxv_cnt - base !== 1)   begin failures++; $display("FAIL ur_rxv_cnt got=%0d exp=1", rxv_cnt - base); end
      checks++; if (rx_data !== 8'h96)      begin failures++; $display("FAIL ur_rx_data got=%h exp=96", rx_data); end
      underrun_clr = 1'b1;
      wait_clk(1);
      underrun_clr = 1'b0;
      checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL ur_clear got=%b exp=0", tx_underrun); end
   endtask

   task automatic test_mode0;
      logic [7:0] got;
      int base;
      set_mode(2'd0);
      load(8'hA5);
      checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_ready_full got=%b exp=0", tx_ready); end
      base = rxv_cnt;
      ssn = 1'b0;
      wait_clk(H);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL m0_ready_start got=%b exp=1", tx_ready); end
      xfer(8'h3C, 1'b0, 1'b0, 8, got);
      wait_clk(H);
      ssn = 1'b1;
      wait_clk(H);
      checks++; if (got !== 8'hA5)        begin failures++; $display("FAIL m0_miso_word got=%h exp=a5", got); end
      checks++; if (rxv_cnt - base !== 1) begin failures++; $display("FAIL m0_rxv_cnt got=%0d exp=1", rxv_cnt - base); end
      checks++; if (rx_data !== 8'h3C)    begin failures++; $display("FAIL m0_rx_data got=%h exp=3c", rx_data); end
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL m0_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_modes;
      logic [7:0] got;
      int base;
      for (int m = 1; m <= 3; m++) begin
         set_mode(2'(m));
         load(8'h81);
         base = rxv_cnt;
         frame(8'h7E, 2'(m), got);
         checks++; if (got !== 8'h81)        begin failures++; $display("FAIL mode%0d_miso_word got=%h exp=81", m, got); end
         checks++; if (rxv_cnt - base !== 1) begin failures++; $display("FAIL mode%0d_rxv_cnt got=%0d exp=1", m, rxv_cnt - base); end
         checks++; if (rx_data !== 8'h7E)    begin failures++; $display("FAIL mode%0d_rx_data got=%h exp=7e", m, rx_data); end
      end
      set_mode(2'd0);
   endtask

   task automatic test_back_to_back;
      logic [7:0] g1, g2;
      int base;
      set_mode(2'd0);
      load(8'h11);
      base = rxv_cnt;
      ssn = 1'b0;
      wait_clk(H);
      fork
         xfer(8'hC3, 1'b0, 1'b0, 8, g1);
         begin
            wait_clk(30);
            load(8'h22);
         end
      join
      xfer(8'h5A, 1'b0, 1'b0, 8, g2);
      wait_clk(H);
      ssn = 1'b1;
      wait_clk(H);
      checks++; if (g1 !== 8'h11)         begin failures++; $display("FAIL b2b_word1_miso got=%h exp=11", g1); end
      checks++; if (g2 !== 8'h22)         begin failures++; $display("FAIL b2b_word2_miso got=%h exp=22", g2); end
      checks++; if (rxv_cnt - base !== 2) begin failures++; $display("FAIL b2b_rxv_cnt got=%0d exp=2", rxv_cnt - base); end
      if (rxv_cnt - base >= 2) begin
         checks++; if (rx_log[base] !== 8'hC3)   begin failures++; $display("FAIL b2b_rx1 got=%h exp=c3", rx_log[base]); end
         checks++; if (rx_log[base+1] !== 8'h5A) begin failures++; $display("FAIL b2b_rx2 got=%h exp=5a", rx_log[base+1]); end
      end
   endtask

   task automatic test_partial;
      logic [7:0] got;
      int base;
      set_mode(2'd0);
      base = rxv_cnt;
      ssn = 1'b0;
      wait_clk(H);
      xfer(8'hFF, 1'b0, 1'b0, 5, got);
      ssn = 1'b1;
      wait_clk(SS + 2);
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL part_busy got=%b exp=0", busy); end
      checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL part_miso_oe got=%b exp=0", miso_oe); end
      wait_clk(H);
      checks++; if (rxv_cnt - base !== 0) begin failures++; $display("FAIL part_no_rxv got=%0d exp=0", rxv_cnt - base); end
      load(8'hAA);
      frame(8'h55, 2'd0, got);
      checks++; if (rxv_cnt - base !== 1) begin failures++; $display("FAIL part_next_rxv got=%0d exp=1", rxv_cnt - base); end
      checks++; if (rx_data !== 8'h55)    begin failures++; $display("FAIL part_next_rx got=%h exp=55", rx_data); end
      checks++; if (got !== 8'hAA)        begin failures++; $display("FAIL part_next_miso got=%h exp=aa", got); end
   endtask

   task automatic test_disabled;
      logic [7:0] got;
      int b0, o0, r0;
      spcon = 8'h00;
      sck   = 1'b0;
      wait_clk(H);
      b0 = busy_cnt; o0 = oe_cnt; r0 = rxv_cnt;
      frame(8'hA5, 2'd0, got);
      checks++; if (busy_cnt - b0 !== 0) begin failures++; $display("FAIL dis_busy cycles=%0d exp=0", busy_cnt - b0); end
      checks++; if (oe_cnt - o0 !== 0)   begin failures++; $display("FAIL dis_miso_oe cycles=%0d exp=0", oe_cnt - o0); end
      checks++; if (rxv_cnt - r0 !== 0)  begin failures++; $display("FAIL dis_rxv got=%0d exp=0", rxv_cnt - r0); end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] got;
      set_mode(2'd0);
      load(8'h99);
      ssn = 1'b0;
      wait_clk(H);
      xfer(8'hF0, 1'b0, 1'b0, 3, got);
      wait_clk(2);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
      rst = 1'b1;
      wait_clk(1);
      checks++; if (miso !== 1'b0)        begin failures++; $display("FAIL mid_miso got=%b exp=0", miso); end
      checks++; if (miso_oe !== 1'b0)     begin failures++; $display("FAIL mid_miso_oe got=%b exp=0", miso_oe); end
      checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL mid_rx_data got=%h exp=00", rx_data); end
      checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL mid_rx_valid got=%b exp=0", rx_valid); end
      checks++; if (tx_ready !== 1'b1)    begin failures++; $display("FAIL mid_tx_ready got=%b exp=1", tx_ready); end
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL mid_underrun got=%b exp=0", tx_underrun); end
      ssn = 1'b1;
      sck = 1'b0;
      wait_clk(H);
      rst = 1'b0;
      wait_clk(H);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle_after got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_underrun();
      test_mode0();
      test_modes();
      test_back_to_back();
      test_partial();
      test_disabled();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
